// File: rtl/tff_arb_pkg.sv
// Shared types and constants for the round-robin toggle arbiter.
package tff_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      COOL  = 2'd2
   } state_e;

   localparam int CNT_W  = 4;
   localparam int STAT_W = 8;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of T flip-flops: each bit flips when its one-hot enable is high.
module tff_bank #(
   parameter int NBITS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NBITS-1:0] tgl_en_i,
   output logic [NBITS-1:0] q_o
);

   logic [NBITS-1:0] q_q;

   always_ff @(posedge clk) begin
      if (reset) q_q <= '0;
      else       q_q <= q_q ^ tgl_en_i;
   end

   assign q_o = q_q;

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter granting one toggle per round into a shared T-flop bank.
// Optional per-requester grant counters are built when TFF_ARB_STATS_EN is defined.
module tff_toggle_arbiter
   import tff_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int NBITS    = 8,
   parameter int COOLDOWN = 2
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NREQ-1:0]                       req,
   input  logic [NREQ-1:0][$clog2(NBITS)-1:0]    req_idx,
   output logic [NREQ-1:0]                       grant,
   output logic [NBITS-1:0]                      q,
   output logic                                  busy
`ifdef TFF_ARB_STATS_EN
   ,
   output logic [NREQ-1:0][STAT_W-1:0]           grant_cnt
`endif
);

   localparam int IDX_W = $clog2(NBITS);
   localparam int PTR_W = $clog2(NREQ);

   state_e            state_q;
   logic [NREQ-1:0]   grant_q;
   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  win_q;
   logic [IDX_W-1:0]  idx_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              win_vld_d;
   logic [PTR_W-1:0]  win_d;
   logic [NBITS-1:0]  tgl_en_d;
   int                cand;

   // Scan offsets from the far end so the nearest requester after ptr wins last.
   always_comb begin
      win_vld_d = 1'b0;
      win_d     = '0;
      cand      = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = (int'(ptr_q) + i) % NREQ;
         if (req[cand]) begin
            win_vld_d = 1'b1;
            win_d     = PTR_W'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         win_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_vld_d) begin
                  win_q   <= win_d;
                  idx_q   <= req_idx[win_d];
                  grant_q <= NREQ'(1) << win_d;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               grant_q <= '0;
               ptr_q   <= (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
               if (COOLDOWN > 0) begin
                  cnt_q   <= CNT_W'(COOLDOWN - 1);
                  state_q <= COOL;
               end else begin
                  state_q <= IDLE;
               end
            end
            COOL: begin
               if (cnt_q == '0) state_q <= IDLE;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Indices at or beyond NBITS shift out of the enable and toggle nothing.
   always_comb begin
      tgl_en_d = '0;
      if (state_q == GRANT) tgl_en_d = NBITS'(1) << idx_q;
   end

   tff_bank #(.NBITS(NBITS)) u_bank (
      .clk      (clk),
      .reset    (reset),
      .tgl_en_i (tgl_en_d),
      .q_o      (q)
   );

`ifdef TFF_ARB_STATS_EN
   logic [NREQ-1:0][STAT_W-1:0] stat_q;

   always_ff @(posedge clk) begin
      if (reset)                  stat_q        <= '0;
      else if (state_q == GRANT)  stat_q[win_q] <= sat_inc(stat_q[win_q]);
   end

   assign grant_cnt = stat_q;
`endif

   assign grant = grant_q;
   assign busy  = (state_q != IDLE);

endmodule
